rtc_secuenciador: RTL and testbench

- Upstream transaction sequencer for the RTC bus-cycle engine.
- Periodically issues six single-register read transactions (seconds, minutes, hours, day, month, year) and publishes a coherent BCD time snapshot.
- Accepts one pending user write (time set) at a time and issues it as a write transaction.
- Drives the engine's start pulse, direction, address and write data; consumes its busy flag, data strobe and read data.

---
 rtl/rtc_secuenciador.sv | 247 ++++++++++++++++++++++++
 tb/tb_rtc_secuenciador.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_secuenciador.sv
// rtc_secuenciador: periodic six-register RTC read scanner plus single-slot
// user write path, driving a start/busy handshake to the RTC bus-cycle engine.
// Ports: clk, reset (async, active-high); engine side flag_in, lee_escribe_m,
//   add, datos (out) and flag_work_s, tomar_dato, data (in); user side
//   wr_req, wr_sel, wr_data (in), wr_ready (out); snapshot seg..anio,
//   frame_valid, busy, err (out).
// Optional: define RTC_INIT_EN to issue a write of INIT_DATA to INIT_ADDR
//   as the first transaction after reset.
module rtc_secuenciador #(
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [7:0]  ADDR_BASE      = 8'h21,
  parameter logic [7:0]  INIT_ADDR      = 8'h02,
  parameter logic [7:0]  INIT_DATA      = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  output logic       flag_in,
  output logic       lee_escribe_m,
  output logic [7:0] add,
  output logic [7:0] datos,
  input  logic       flag_work_s,
  input  logic       tomar_dato,
  input  logic [7:0] data,
  input  logic       wr_req,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       frame_valid,
  output logic       busy,
  output logic       err
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, NEXT
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   ref_q, ref_d;
  logic            scan_q, scan_d;
  logic [2:0]      idx_q, idx_d;
  logic            wr_pend_q, wr_pend_d;
  logic [2:0]      wr_sel_q, wr_sel_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            flag_q, flag_d;
  logic            dir_q, dir_d;
  logic [7:0]      add_q, add_d;
  logic [7:0]      datos_q, datos_d;
  logic            fv_q, fv_d;
  logic            err_q, err_d;
  logic [7:0]      sh_q [6];
  logic [7:0]      sh_d [6];
  logic [7:0]      snap_q [6];
  logic [7:0]      snap_d [6];
  logic            wrap;
  logic            init_pend;

`ifdef RTC_INIT_EN
  logic init_q, init_d;
  assign init_pend = init_q;
`else
  assign init_pend = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q + RW'(1);
    scan_d    = scan_q;
    idx_d     = idx_q;
    wr_pend_d = wr_pend_q;
    wr_sel_d  = wr_sel_q;
    wr_data_d = wr_data_q;
    tmo_d     = tmo_q;
    flag_d    = 1'b0;
    dir_d     = dir_q;
    add_d     = add_q;
    datos_d   = datos_q;
    fv_d      = 1'b0;
    err_d     = err_q;
    sh_d      = sh_q;
    snap_d    = snap_q;
`ifdef RTC_INIT_EN
    init_d    = init_q;
`endif

    wrap = (ref_q == RW'(REFRESH_CYCLES - 1));
    if (wrap) ref_d = '0;

    unique case (state_q)
      IDLE: begin
        // A pending write only preempts the scan between frames (idx 0).
        if (init_pend) begin
          add_d   = INIT_ADDR;
          datos_d = INIT_DATA;
          dir_d   = 1'b1;
          flag_d  = 1'b1;
          state_d = ISSUE;
        end else if (wr_pend_q && idx_q == 3'd0) begin
          add_d   = ADDR_BASE + 8'(wr_sel_q);
          datos_d = wr_data_q;
          dir_d   = 1'b1;
          flag_d  = 1'b1;
          state_d = ISSUE;
        end else if (scan_q) begin
          add_d   = ADDR_BASE + 8'(idx_q);
          datos_d = 8'h00;
          dir_d   = 1'b0;
          flag_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Counts the flag_in cycle, so err lands TIMEOUT cycles after it.
        tmo_d   = TW'(1);
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (flag_work_s) begin
          state_d = WAIT_DONE;
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          idx_d     = 3'd0;
          scan_d    = 1'b0;
          wr_pend_d = 1'b0;
`ifdef RTC_INIT_EN
          init_d    = 1'b0;
`endif
          for (int i = 0; i < 6; i++) sh_d[i] = 8'h00;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!dir_q && tomar_dato) begin
          for (int i = 0; i < 6; i++)
            if (idx_q == 3'(i)) sh_d[i] = data;
        end
        if (!flag_work_s) state_d = NEXT;
      end
      NEXT: begin
        state_d = IDLE;
        if (dir_q) begin
`ifdef RTC_INIT_EN
          if (init_q) init_d = 1'b0;
          else        wr_pend_d = 1'b0;
`else
          wr_pend_d = 1'b0;
`endif
          scan_d = 1'b1;
        end else if (idx_q == 3'd5) begin
          for (int i = 0; i < 6; i++) snap_d[i] = sh_q[i];
          fv_d   = 1'b1;
          idx_d  = 3'd0;
          scan_d = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A refresh tick must never be lost to a same-cycle clear.
    if (wrap) scan_d = 1'b1;

    // Applied after the FSM so an abort cannot drop a fresh request.
    if (wr_req && wr_ready && wr_sel <= 3'd5) begin
      wr_pend_d = 1'b1;
      wr_sel_d  = wr_sel;
      wr_data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ref_q     <= '0;
      scan_q    <= 1'b1;
      idx_q     <= 3'd0;
      wr_pend_q <= 1'b0;
      wr_sel_q  <= 3'd0;
      wr_data_q <= 8'h00;
      tmo_q     <= '0;
      flag_q    <= 1'b0;
      dir_q     <= 1'b0;
      add_q     <= 8'h00;
      datos_q   <= 8'h00;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        sh_q[i]   <= 8'h00;
        snap_q[i] <= 8'h00;
      end
`ifdef RTC_INIT_EN
      init_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      wr_pend_q <= wr_pend_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
      flag_q    <= flag_d;
      dir_q     <= dir_d;
      add_q     <= add_d;
      datos_q   <= datos_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      for (int i = 0; i < 6; i++) begin
        sh_q[i]   <= sh_d[i];
        snap_q[i] <= snap_d[i];
      end
`ifdef RTC_INIT_EN
      init_q    <= init_d;
`endif
    end
  end

  assign flag_in       = flag_q;
  assign lee_escribe_m = dir_q;
  assign add           = add_q;
  assign datos         = datos_q;
  assign wr_ready      = ~wr_pend_q & ~init_pend;
  assign seg           = snap_q[0];
  assign min           = snap_q[1];
  assign hora          = snap_q[2];
  assign dia           = snap_q[3];
  assign mes           = snap_q[4];
  assign anio          = snap_q[5];
  assign frame_valid   = fv_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_rtc_secuenciador.sv
// tb_rtc_secuenciador: directed bench for rtc_secuenciador with a behavioural
// bus-engine/RTC model and queue scoreboards for transactions and frames.
module tb_rtc_secuenciador;

  localparam int REF = 600;
  localparam int TMO = 20;
  localparam logic [47:0] F1 = 48'h45_30_12_07_03_17;
  localparam logic [47:0] F2 = 48'h45_59_12_07_03_17;

  typedef struct packed {
    logic       dir;
    logic [7:0] a;
    logic [7:0] d;
  } txn_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flag_in, lee_escribe_m;
  logic [7:0] add, datos;
  logic       flag_work_s, tomar_dato;
  logic [7:0] data;
  logic       wr_req;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       frame_valid, busy, err;

  txn_t        exp_q[$];
  logic [47:0] fexp_q[$];
  logic [7:0]  rtc_mem [6];
  bit          eng_en = 1'b1;
  int          n_chk = 0;
  int          n_pass = 0;
  int          fv_cnt = 0;
  int          ea;
  int          n;
  txn_t        mt;
  logic [47:0] mf;

  rtc_secuenciador #(
    .REFRESH_CYCLES(REF),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .flag_in(flag_in), .lee_escribe_m(lee_escribe_m),
    .add(add), .datos(datos),
    .flag_work_s(flag_work_s), .tomar_dato(tomar_dato), .data(data),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data),
    .wr_ready(wr_ready),
    .seg(seg), .min(min), .hora(hora), .dia(dia), .mes(mes), .anio(anio),
    .frame_valid(frame_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_txn(input logic dir, input logic [7:0] a,
                          input logic [7:0] d);
    txn_t t;
    t.dir = dir; t.a = a; t.d = d;
    exp_q.push_back(t);
  endtask

  task automatic push_scan(input logic [47:0] f);
    for (int i = 0; i < 6; i++) push_txn(1'b0, 8'h21 + 8'(i), 8'h00);
    fexp_q.push_back(f);
  endtask

  task automatic wait_fv(input int target, input int budget);
    int k = 0;
    while (fv_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", fv_cnt, target);
  endtask

  task automatic wait_txn(input logic [7:0] a, input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(flag_in && add == a) && k < budget);
    chk("txn_seen", 32'(flag_in && add == a), 1);
  endtask

  // Engine: busy 30 cycles per transaction, read strobe on the last one.
  initial begin
    flag_work_s = 1'b0;
    tomar_dato  = 1'b0;
    data        = 8'h00;
    forever begin
      @(posedge clk);
      if (flag_in && eng_en && !reset) begin
        ea = int'(add) - 'h21;
        #1 flag_work_s = 1'b1;
        if (lee_escribe_m && ea >= 0 && ea < 6) rtc_mem[ea] = datos;
        repeat (29) @(posedge clk);
        #1;
        if (!lee_escribe_m && ea >= 0 && ea < 6) begin
          data       = rtc_mem[ea];
          tomar_dato = 1'b1;
        end
        @(posedge clk);
        #1;
        tomar_dato  = 1'b0;
        flag_work_s = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && flag_in) begin
      chk("txn_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mt = exp_q.pop_front();
        chk("txn_dir", lee_escribe_m, mt.dir);
        chk("txn_add", add, mt.a);
        chk("txn_datos", datos, mt.d);
      end
    end
    if (!reset && frame_valid) begin
      fv_cnt++;
      chk("frame_expected", 32'(fexp_q.size() > 0), 1);
      if (fexp_q.size() > 0) begin
        mf = fexp_q.pop_front();
        chk("frame_seg", seg, mf[47:40]);
        chk("frame_min", min, mf[39:32]);
        chk("frame_hora", hora, mf[31:24]);
        chk("frame_dia", dia, mf[23:16]);
        chk("frame_mes", mes, mf[15:8]);
        chk("frame_anio", anio, mf[7:0]);
      end
    end
  end

  initial begin
    wr_req  = 1'b0;
    wr_sel  = 3'd0;
    wr_data = 8'h00;
    rtc_mem = '{8'h45, 8'h30, 8'h12, 8'h07, 8'h03, 8'h17};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_flag_in", flag_in, 0);
    chk("rst_add", add, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_seg", seg, 0);
    chk("rst_frame_valid", frame_valid, 0);
`ifdef RTC_INIT_EN
    chk("rst_wr_ready", wr_ready, 0);
    push_txn(1'b1, 8'h02, 8'h10);
`else
    chk("rst_wr_ready", wr_ready, 1);
`endif

    // First scan straight after reset release
    push_scan(F1);
    reset = 1'b0;
    wait_fv(1, 1000);
    chk("scan1_idle", busy, 0);
    chk("scan1_wr_ready", wr_ready, 1);
    chk("scan1_drained", exp_q.size(), 0);

    // Write arriving mid-scan waits for the frame
    push_scan(F1);
    wait_txn(8'h23, 1000);
    @(negedge clk);
    wr_req  = 1'b1;
    wr_sel  = 3'd1;
    wr_data = 8'h59;
    push_txn(1'b1, 8'h22, 8'h59);
    push_scan(F2);
    @(negedge clk);
    wr_req = 1'b0;
    chk("midscan_wr_ready", wr_ready, 0);
    wait_fv(2, 1000);
    chk("frame_wr_still_pending", wr_ready, 0);
    wait_fv(3, 1000);
    chk("post_write_wr_ready", wr_ready, 1);
    chk("scan3_drained", exp_q.size(), 0);

    // Out-of-range index is ignored
    push_scan(F2);
    @(negedge clk);
    wr_req  = 1'b1;
    wr_sel  = 3'd6;
    wr_data = 8'h99;
    @(negedge clk);
    wr_req = 1'b0;
    chk("sel6_wr_ready", wr_ready, 1);
    wait_fv(4, 1000);
    chk("scan4_drained", exp_q.size(), 0);

    // Engine never starts: timeout, then retry on next refresh
    eng_en = 1'b0;
    push_txn(1'b0, 8'h21, 8'h00);
    wait_txn(8'h21, 1000);
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, TMO);
    chk("timeout_idle", busy, 0);
    eng_en = 1'b1;
    push_scan(F2);
    wait_fv(5, 1000);
    chk("err_sticky", err, 1);
    chk("retry_drained", exp_q.size(), 0);

    // Reset during WAIT_DONE
    push_txn(1'b0, 8'h21, 8'h00);
    wait_txn(8'h21, 1000);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst2_flag_in", flag_in, 0);
    chk("rst2_add", add, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_err", err, 0);
    chk("rst2_seg", seg, 0);
`ifdef RTC_INIT_EN
    chk("rst2_wr_ready", wr_ready, 0);
`else
    chk("rst2_wr_ready", wr_ready, 1);
`endif
    repeat (40) @(negedge clk);
`ifdef RTC_INIT_EN
    push_txn(1'b1, 8'h02, 8'h10);
`endif
    push_scan(F2);
    reset = 1'b0;
    wait_fv(6, 1000);
    chk("final_drained", exp_q.size(), 0);
    chk("final_frames_drained", fexp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
